// File: rtl/spi_regfile_ctrl_pkg.sv
// Shared definitions for the SPI register-file controller: FSM states,
// command byte field positions and the idle MISO byte.
package spi_regfile_ctrl_pkg;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned RD_BIT   = 7;
    localparam int unsigned ADDR_MSB = 3;
    localparam int unsigned ADDR_W   = ADDR_MSB + 1;

    localparam logic [BYTE_W-1:0] IDLE_TX = 8'h00;

    typedef enum logic [1:0] {
        ST_ARM0 = 2'd0,
        ST_CMD  = 2'd1,
        ST_WR   = 2'd2,
        ST_RD   = 2'd3
    } state_t;

    // Command byte: bit RD_BIT selects read, bits [ADDR_MSB:0] give the start address.
    function automatic logic cmd_is_rd(input logic [BYTE_W-1:0] b);
        return b[RD_BIT];
    endfunction

    function automatic logic [ADDR_W-1:0] cmd_addr(input logic [BYTE_W-1:0] b);
        return b[ADDR_MSB:0];
    endfunction

endpackage

// File: rtl/spi_regbank.sv
// Bank of NREG byte registers with one write port and one combinational read port.
// Out-of-range write addresses are ignored; out-of-range reads return zero.
module spi_regbank
    import spi_regfile_ctrl_pkg::*;
#(
    parameter int unsigned       NREG    = 8,
    parameter logic [BYTE_W-1:0] RST_VAL = 8'h00
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [BYTE_W-1:0]        wdata,
    input  logic [ADDR_W-1:0]        raddr,
    output logic [BYTE_W-1:0]        rdata,
    output logic [NREG*BYTE_W-1:0]   regs_flat
);

    logic [BYTE_W-1:0] regs [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(NREG); k++) begin
                regs[k] <= RST_VAL;
            end
        end else if (we) begin
            for (int k = 0; k < int'(NREG); k++) begin
                if (waddr == ADDR_W'(k)) begin
                    regs[k] <= wdata;
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < int'(NREG); k++) begin
            if (raddr == ADDR_W'(k)) begin
                rdata = regs[k];
            end
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int k = 0; k < int'(NREG); k++) begin
            regs_flat[k*BYTE_W +: BYTE_W] = regs[k];
        end
    end

endmodule

// File: rtl/spi_regfile_ctrl.sv
// SPI slave command decoder: first byte of a frame is a read/write command with a
// start address, following bytes stream into or out of the register bank.
module spi_regfile_ctrl
    import spi_regfile_ctrl_pkg::*;
#(
    parameter int unsigned       NREG    = 8,
    parameter logic [BYTE_W-1:0] RST_VAL = 8'h00
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ss,
    input  logic [BYTE_W-1:0]      rx_byte,
    input  logic                   rx_valid,
    output logic [BYTE_W-1:0]      tx_byte,
    output logic                   tx_en,
    output logic [NREG*BYTE_W-1:0] cfg_out,
    output logic                   wr_strobe,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic                   frame_act
);

    localparam logic [ADDR_W:0] NREG_L = (ADDR_W+1)'(NREG);

    logic ss_meta;
    logic ss_sync;
    logic frame_start;
    logic frame_end;
    logic byte_ok;

    state_t              state, state_d;
    logic [ADDR_W-1:0]   ptr, ptr_d;
    logic [BYTE_W-1:0]   tx_byte_d;
    logic                tx_en_d;
    logic [ADDR_W-1:0]   raddr;
    logic [BYTE_W-1:0]   rdata;
    logic                wr_en;

    // Pin synchroniser; frame_act lags ss_sync by one cycle so edges fall out of the pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_meta   <= 1'b1;
            ss_sync   <= 1'b1;
            frame_act <= 1'b0;
        end else begin
            ss_meta   <= ss;
            ss_sync   <= ss_meta;
            frame_act <= ~ss_sync;
        end
    end

    assign frame_start = ~frame_act & ~ss_sync;
    assign frame_end   =  frame_act &  ss_sync;
    assign byte_ok     =  rx_valid & frame_act;

    // Writes commit in the rx_valid cycle, so the strobe is combinational.
    assign wr_en     = (state == ST_WR) && byte_ok && ({1'b0, ptr} < NREG_L);
    assign wr_strobe = wr_en;
    assign wr_addr   = ptr;

    always_comb begin
        raddr = (state == ST_CMD) ? cmd_addr(rx_byte) : ADDR_W'(ptr + 4'd1);
    end

    spi_regbank #(
        .NREG    (NREG),
        .RST_VAL (RST_VAL)
    ) u_regbank (
        .clk       (clk),
        .rst       (rst),
        .we        (wr_en),
        .waddr     (ptr),
        .wdata     (rx_byte),
        .raddr     (raddr),
        .rdata     (rdata),
        .regs_flat (cfg_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_ARM0;
            ptr     <= '0;
            tx_byte <= IDLE_TX;
            tx_en   <= 1'b0;
        end else begin
            state   <= state_d;
            ptr     <= ptr_d;
            tx_byte <= tx_byte_d;
            tx_en   <= tx_en_d;
        end
    end

    always_comb begin
        state_d   = state;
        ptr_d     = ptr;
        tx_byte_d = tx_byte;
        tx_en_d   = 1'b0;

        unique case (state)
            ST_ARM0: begin
                tx_en_d   = 1'b1;
                tx_byte_d = IDLE_TX;
                state_d   = ST_CMD;
            end
            ST_CMD: begin
                if (byte_ok) begin
                    ptr_d   = cmd_addr(rx_byte);
                    tx_en_d = 1'b1;
                    if (cmd_is_rd(rx_byte)) begin
                        tx_byte_d = rdata;
                        state_d   = ST_RD;
                    end else begin
                        tx_byte_d = IDLE_TX;
                        state_d   = ST_WR;
                    end
                end
            end
            ST_WR: begin
                if (byte_ok) begin
                    ptr_d     = ptr + 4'd1;
                    tx_en_d   = 1'b1;
                    tx_byte_d = IDLE_TX;
                end
            end
            ST_RD: begin
                if (byte_ok) begin
                    ptr_d     = ptr + 4'd1;
                    tx_en_d   = 1'b1;
                    tx_byte_d = rdata;
                end
            end
            default: state_d = ST_CMD;
        endcase

        // A byte landing with frame end is still processed above; the engine's armed byte stays put.
        if (frame_end || (frame_start && state != ST_CMD)) begin
            state_d = ST_CMD;
        end
    end

endmodule

// File: tb/tb_spi_regfile_ctrl.sv
// Scoreboard bench: two controllers (NREG=8 with a non-zero reset value, NREG=16)
// share one stimulus stream and are checked against a frame-level reference model.
module tb_spi_regfile_ctrl;

    localparam int NI = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ss  = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte  = 8'h00;

    logic [NI-1:0][7:0] tx_byte_w;
    logic [NI-1:0]      tx_en_w;
    logic [NI-1:0]      wr_strobe_w;
    logic [NI-1:0][3:0] wr_addr_w;
    logic [NI-1:0]      frame_act_w;
    logic [8*8-1:0]     cfg_a;
    logic [16*8-1:0]    cfg_b;

    always #5 clk = ~clk;

    spi_regfile_ctrl #(.NREG(8), .RST_VAL(8'h3C)) u_dut8 (
        .clk(clk), .rst(rst), .ss(ss), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .tx_byte(tx_byte_w[0]), .tx_en(tx_en_w[0]), .cfg_out(cfg_a),
        .wr_strobe(wr_strobe_w[0]), .wr_addr(wr_addr_w[0]), .frame_act(frame_act_w[0])
    );

    spi_regfile_ctrl #(.NREG(16), .RST_VAL(8'h00)) u_dut16 (
        .clk(clk), .rst(rst), .ss(ss), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .tx_byte(tx_byte_w[1]), .tx_en(tx_en_w[1]), .cfg_out(cfg_b),
        .wr_strobe(wr_strobe_w[1]), .wr_addr(wr_addr_w[1]), .frame_act(frame_act_w[1])
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: register contents, address pointer and frame phase per instance.
    int         nreg [NI] = '{8, 16};
    logic [7:0] rstv [NI] = '{8'h3C, 8'h00};
    logic [7:0] mregs [NI][16];
    int         mptr  [NI];
    int         mmode [NI];   // 0: expecting command, 1: writing, 2: reading
    bit         mframe = 1'b0;
    logic [7:0] exp_tx [NI][$];
    logic [3:0] exp_wr [NI][$];
    bit         prev_en [NI];

    task automatic report(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0h expected %0h", name, i, act, exp);
        end
    endtask

    function automatic logic [7:0] mread(input int i, input int a);
        return (a < nreg[i]) ? mregs[i][a] : 8'h00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 16; k++) mregs[i][k] = rstv[i];
            mptr[i]  = 0;
            mmode[i] = 0;
            exp_tx[i].delete();
            exp_wr[i].delete();
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input bit active);
        if (!active) return;
        for (int i = 0; i < NI; i++) begin
            case (mmode[i])
                0: begin
                    mptr[i] = int'(b[3:0]);
                    if (b[7]) begin
                        mmode[i] = 2;
                        exp_tx[i].push_back(mread(i, mptr[i]));
                    end else begin
                        mmode[i] = 1;
                        exp_tx[i].push_back(8'h00);
                    end
                end
                1: begin
                    if (mptr[i] < nreg[i]) begin
                        exp_wr[i].push_back(4'(mptr[i]));
                        mregs[i][mptr[i]] = b;
                    end
                    mptr[i] = (mptr[i] + 1) % 16;
                    exp_tx[i].push_back(8'h00);
                end
                default: begin
                    mptr[i] = (mptr[i] + 1) % 16;
                    exp_tx[i].push_back(mread(i, mptr[i]));
                end
            endcase
        end
    endtask

    function automatic logic [7:0] cfg_byte(input int i, input int k);
        return (i == 0) ? cfg_a[k*8 +: 8] : cfg_b[k*8 +: 8];
    endfunction

    task automatic check_regs(input string name);
        for (int i = 0; i < NI; i++)
            for (int k = 0; k < nreg[i]; k++)
                report(name, i, 32'(cfg_byte(i, k)), 32'(mregs[i][k]));
    endtask

    task automatic check_frame_act(input logic exp);
        for (int i = 0; i < NI; i++) report("frame_act", i, 32'(frame_act_w[i]), 32'(exp));
    endtask

    // Monitor: every tx_en / wr_strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < NI; i++) prev_en[i] = 1'b0;
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (tx_en_w[i]) begin
                    report("tx_en_gap", i, 32'(prev_en[i]), 32'd0);
                    if (exp_tx[i].size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL tx_en_unexpected dut%0d: got tx_byte %0h expected no pulse", i, tx_byte_w[i]);
                    end else begin
                        report("tx_byte", i, 32'(tx_byte_w[i]), 32'(exp_tx[i].pop_front()));
                    end
                end
                if (wr_strobe_w[i]) begin
                    if (exp_wr[i].size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL wr_strobe_unexpected dut%0d: got wr_addr %0h expected no pulse", i, wr_addr_w[i]);
                    end else begin
                        report("wr_addr", i, 32'(wr_addr_w[i]), 32'(exp_wr[i].pop_front()));
                    end
                end
                prev_en[i] = tx_en_w[i];
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        model_byte(b, mframe);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        idle($urandom_range(1, 3));
    endtask

    task automatic frame_begin();
        ss = 1'b0;
        idle(5);
        mframe = 1'b1;
        for (int i = 0; i < NI; i++) mmode[i] = 0;
        check_frame_act(1'b1);
    endtask

    task automatic frame_close();
        ss = 1'b1;
        idle(5);
        mframe = 1'b0;
        for (int i = 0; i < NI; i++) mmode[i] = 0;
        check_frame_act(1'b0);
    endtask

    task automatic release_reset();
        for (int i = 0; i < NI; i++) exp_tx[i].push_back(8'h00);
        rst = 1'b0;
        idle(4);
    endtask

    initial begin
        model_reset();
        idle(3);
        for (int i = 0; i < NI; i++) begin
            report("rst_tx_en", i, 32'(tx_en_w[i]), 32'd0);
            report("rst_tx_byte", i, 32'(tx_byte_w[i]), 32'd0);
            report("rst_wr_strobe", i, 32'(wr_strobe_w[i]), 32'd0);
            report("rst_wr_addr", i, 32'(wr_addr_w[i]), 32'd0);
        end
        check_frame_act(1'b0);
        check_regs("rst_regs");
        release_reset();

        // Burst write starting at 2.
        frame_begin(); send(8'h02); send(8'hAB); send(8'hCD); frame_close();
        check_regs("wr_burst");

        // Preload 5/6, then read them back.
        frame_begin(); send(8'h05); send(8'h5A); send(8'h66); frame_close();
        frame_begin(); send(8'h85); send(8'h00); send(8'hFF); frame_close();

        // Write running off the end of an 8-register bank.
        frame_begin(); send(8'h07); send(8'h11); send(8'h22); frame_close();
        check_regs("wr_edge");

        // Read wrapping from 15 to 0.
        frame_begin(); send(8'h0F); send(8'h9E); frame_close();
        frame_begin(); send(8'h8F); send(8'h12); send(8'h34); frame_close();

        // Reset in the middle of a write frame.
        frame_begin(); send(8'h01); send(8'h42);
        idle(2);
        rst = 1'b1;
        idle(2);
        model_reset();
        check_regs("midframe_rst");
        release_reset();
        idle(4);
        mframe = 1'b1;
        frame_close();
        frame_begin(); send(8'h01); send(8'h77); frame_close();
        check_regs("after_rst");

        // Data byte coinciding with the synchronised rise of ss.
        frame_begin(); send(8'h04);
        ss = 1'b1;
        idle(2);
        model_byte(8'hC3, 1'b1);
        rx_byte  = 8'hC3;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        mframe = 1'b0;
        for (int i = 0; i < NI; i++) mmode[i] = 0;
        idle(4);
        check_frame_act(1'b0);
        send(8'h99);
        frame_begin(); send(8'h84); send(8'h00); frame_close();
        check_regs("edge_wr");

        // Random frames.
        for (int f = 0; f < 40; f++) begin
            logic [7:0] cmd;
            cmd = 8'($urandom);
            frame_begin();
            send(cmd);
            for (int d = 0; d < int'($urandom_range(0, 4)); d++) send(8'($urandom));
            frame_close();
        end
        check_regs("rand_regs");

        idle(5);
        for (int i = 0; i < NI; i++) begin
            report("tx_pending", i, 32'(exp_tx[i].size()), 32'd0);
            report("wr_pending", i, 32'(exp_wr[i].size()), 32'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_regfile_ctrl.md
SPI_REGFILE_CTRL -- requirements
Module: spi_regfile_ctrl

Interface
REQ-001 Parameter NREG, default 8, meaning number of implemented 8-bit registers (1..16).
REQ-002 Parameter RST_VAL, default 8'h00, meaning reset value of every register.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ss  input  1  raw SPI slave select from pin, active low; asynchronous to clk.
REQ-006 rx_byte  input  8  byte received by the SPI byte engine.
REQ-007 rx_valid  input  1  one-cycle pulse; rx_byte is valid.
REQ-008 tx_byte  output  8  byte for the engine to shift out next; registered.
REQ-009 tx_en  output  1  one-cycle pulse; the engine latches tx_byte and arms for one byte.
REQ-010 cfg_out  output  NREG*8  flattened register contents, reg[k] at bits [8k+7:8k].
REQ-011 wr_strobe  output  1  one-cycle pulse when a register is written.
REQ-012 wr_addr  output  4  address of the register written with wr_strobe.
REQ-013 frame_act  output  1  high while a frame is in progress (synchronised ss low).

Function
REQ-014 ss SHALL pass through a 2-flop synchroniser; frame start is a synchronised falling edge and frame end is a synchronised rising edge.
REQ-015 The FSM SHALL have states ARM0, CMD, WR and RD.
REQ-016 ARM0 SHALL be entered only from reset, SHALL pulse tx_en with tx_byte=8'h00 for one cycle and SHALL go to CMD on the next cycle.
REQ-017 In CMD, on rx_valid the block SHALL decode rx_byte as follows: bit7 = 1 for read, 0 for write; bits[3:0] = start address; bits[6:4] are ignored.
REQ-018 After a CMD byte with bit7=1, the block SHALL load ptr=addr, pulse tx_en one cycle after rx_valid with tx_byte=rdata(addr), and go to RD.
REQ-019 After a CMD byte with bit7=0, the block SHALL load ptr=addr, pulse tx_en one cycle after rx_valid with tx_byte=8'h00, and go to WR.
REQ-020 In WR, on each rx_valid: if ptr<NREG, reg[ptr] SHALL be written with rx_byte and wr_strobe/wr_addr=ptr SHALL be pulsed in the same cycle; ptr SHALL then increment; tx_en SHALL pulse one cycle later with 8'h00.
REQ-021 In RD, on each rx_valid, ptr SHALL increment and tx_en SHALL pulse one cycle later with tx_byte=rdata(ptr+1); rx_byte SHALL be ignored.
REQ-022 rdata(a) SHALL be reg[a] for a<NREG and 8'h00 otherwise; writes to a>=NREG SHALL be dropped without a wr_strobe.
REQ-023 ptr SHALL be 4 bits and SHALL wrap from 15 to 0.
REQ-024 On frame end the FSM SHALL go to CMD without issuing tx_en, because the engine already holds one armed byte; that byte is don't-care to the host as MISO byte 0 of the next frame.
REQ-025 If rx_valid and frame end occur in the same cycle, the byte SHALL be fully processed (write committed, tx_en issued) and the FSM SHALL then be in CMD.
REQ-026 rx_valid SHALL be ignored while frame_act=0, except as covered by REQ-025.
REQ-027 A frame start seen in any state other than CMD SHALL force CMD.
REQ-028 tx_en SHALL never be high on two consecutive cycles, and SHALL pulse exactly once per rx_valid processed in CMD, WR or RD.
REQ-029 Latency SHALL be rx_valid to wr_strobe 0 cycles and rx_valid to tx_en 1 cycle.

Reset
REQ-030 While rst=1: state=ARM0, ptr=0, all registers=RST_VAL, tx_byte=8'h00, tx_en=0, wr_strobe=0, wr_addr=0, frame_act=0, and the synchroniser flops=1.
REQ-031 Reset asserted mid-frame SHALL discard the frame; after release the block SHALL re-arm via ARM0 and SHALL accept the next byte as a CMD byte.

Structure
REQ-032 A shared package SHALL hold the state encoding, the CMD bit positions (RD_BIT=7, ADDR_MSB=3) and the idle tx byte 8'h00.
REQ-033 The register array with its read mux SHALL be one sub-module, spi_regbank (write port plus a combinational read port).

Verification
REQ-034 Reset, then frame CMD 8'h02, data 8'hAB, 8'hCD -> reg2=8'hAB, reg3=8'hCD; two wr_strobe pulses with wr_addr 2 then 3.
REQ-035 Preload reg5=8'h5A, reg6=8'h66; frame CMD 8'h85 plus 2 dummy bytes -> MISO bytes 1 and 2 = 8'h5A, 8'h66; tx_en issued 1 cycle after each rx_valid.
REQ-036 NREG=8, write frame CMD 8'h07, data 8'h11, 8'h22 -> reg7=8'h11, the second byte is dropped, and only one wr_strobe is issued.
REQ-037 Read frame CMD 8'h8F with 2 dummy bytes and NREG=16 -> MISO bytes 1 and 2 = reg15, reg0 (wrap).
REQ-038 Assert rst after the data byte's rx_valid in a write frame to addr 1 -> reg1=RST_VAL; the next frame CMD 8'h01, 8'h77 -> reg1=8'h77.
REQ-039 Deliver rx_valid in the same cycle as the synchronised ss rise during a write to addr 4 -> reg4 is written, tx_en pulses once, and the FSM is in CMD.
